// File: rtl/present_stream_loader_pkg.sv
// Shared constants for the PRESENT stream loader: core widths, byte width,
// loader FSM states and byte-counter widths.
`ifndef SIZE
`define SIZE 64
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 80
`endif

package present_stream_loader_pkg;

    localparam int LOADER_BYTE_W = 8;

    // Counter width able to index nbytes byte positions (at least 1 bit).
    function automatic int byte_cnt_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

    localparam int KEY_BYTES   = `KEY_SIZE / LOADER_BYTE_W;
    localparam int BLOCK_BYTES = `SIZE / LOADER_BYTE_W;
    localparam int KEY_CNT_W   = byte_cnt_width(KEY_BYTES);
    localparam int BLOCK_CNT_W = byte_cnt_width(BLOCK_BYTES);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/present_stream_loader_byte_shift_reg.sv
// byte_shift_reg: WIDTH-bit register filled or drained one byte at a time
// from the MSB end, with a byte position counter that wraps after the last
// byte. A parallel load also restarts the counter.
module byte_shift_reg
    import present_stream_loader_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_shift_in,
    input  logic [7:0]       i_byte,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_out,
    output logic [WIDTH-1:0] o_data,
    output logic             o_first,
    output logic             o_last
);
    localparam int NBYTES = WIDTH / LOADER_BYTE_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       w_fill;
    logic [WIDTH-1:0] w_shifted;

    // Shifting out drains zeros into the LSBs.
    assign w_fill = i_shift_in ? i_byte : 8'h00;

    generate
        if (WIDTH > LOADER_BYTE_W) begin : g_wide
            assign w_shifted = {r_data[WIDTH-LOADER_BYTE_W-1:0], w_fill};
        end else begin : g_byte
            assign w_shifted = w_fill;
        end
    endgenerate

    // Data and position counter: parallel load wins over byte shifting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= '0;
        end else if (i_shift_in || i_shift_out) begin
            r_data <= w_shifted;
            r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_first = (r_cnt == '0);
    assign o_last  = (r_cnt == LAST_IDX);

endmodule

// File: rtl/present_stream_loader.sv
// present_stream_loader: byte-stream front end for the PRESENT core.
// Collects key and plaintext bytes, runs the core until Done, then streams
// the ciphertext out MSB-first.
// Optional feature: define PRESENT_BLOCK_CNT_EN to enable the 16-bit
// completed-block counter on blk_count (otherwise blk_count is tied to 0).
module present_stream_loader
    import present_stream_loader_pkg::*;
#(
    parameter int BLOCK_BITS = `SIZE,
    parameter int KEY_BITS   = `KEY_SIZE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            in_data,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KEY_BITS-1:0]   core_key,
    output logic [BLOCK_BITS-1:0] core_plaintext,
    output logic                  core_enable,
    input  logic                  core_done,
    input  logic [BLOCK_BITS-1:0] core_ciphertext,
    output logic                  key_loaded,
    output logic [15:0]           blk_count
);
    localparam int KEY_NB = KEY_BITS / LOADER_BYTE_W;
    localparam int BLK_NB = BLOCK_BITS / LOADER_BYTE_W;
    localparam int KEY_CW = byte_cnt_width(KEY_NB);
    localparam int BLK_CW = byte_cnt_width(BLK_NB);

    loader_state_t r_state;
    loader_state_t w_state_next;
    logic          r_key_loaded;

    logic w_load;
    logic w_key_accept;
    logic w_blk_accept;
    logic w_out_accept;
    logic w_capture;
    logic w_key_first;
    logic w_key_last;
    logic w_blk_first;
    logic w_blk_last;
    logic w_out_first;
    logic w_out_last;

    logic [KEY_BITS-1:0]   w_key_reg;
    logic [BLOCK_BITS-1:0] w_blk_reg;
    logic [BLOCK_BITS-1:0] w_out_reg;

    // Handshakes are qualified by registered state only, never by in_valid
    // feeding back into in_ready.
    assign w_load       = (r_state == LOAD);
    assign w_key_accept = w_load && in_valid && in_is_key;
    assign w_blk_accept = w_load && in_valid && !in_is_key && r_key_loaded;
    assign w_out_accept = (r_state == OUT) && out_ready;
    assign w_capture    = (r_state == FINAL);

    byte_shift_reg #(.WIDTH(KEY_BITS), .CNT_W(KEY_CW)) u_key_reg (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_shift_in  (w_key_accept),
        .i_byte      (in_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift_out (1'b0),
        .o_data      (w_key_reg),
        .o_first     (w_key_first),
        .o_last      (w_key_last)
    );

    byte_shift_reg #(.WIDTH(BLOCK_BITS), .CNT_W(BLK_CW)) u_blk_reg (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_shift_in  (w_blk_accept),
        .i_byte      (in_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift_out (1'b0),
        .o_data      (w_blk_reg),
        .o_first     (w_blk_first),
        .o_last      (w_blk_last)
    );

    byte_shift_reg #(.WIDTH(BLOCK_BITS), .CNT_W(BLK_CW)) u_out_reg (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_shift_in  (1'b0),
        .i_byte      (8'h00),
        .i_load      (w_capture),
        .i_load_data (core_ciphertext),
        .i_shift_out (w_out_accept),
        .o_data      (w_out_reg),
        .o_first     (w_out_first),
        .o_last      (w_out_last)
    );

    // Position flags not needed for the block and output registers.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_blk_first, w_out_first};

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake/core controls.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        core_enable  = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            LOAD: begin
                // Plaintext waits until a full key is held.
                in_ready = in_is_key || r_key_loaded;
                if (w_blk_accept && w_blk_last) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                core_enable = 1'b1;
                if (core_done) begin
                    w_state_next = FINAL;
                end
            end
            FINAL: begin
                // Ciphertext is valid this cycle; it is captured by u_out_reg.
                core_enable  = 1'b1;
                w_state_next = OUT;
            end
            OUT: begin
                // Enable low lets the core reset and reload for the next block.
                out_valid = 1'b1;
                if (out_ready && w_out_last) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    // Key-held flag: dropped by the first byte of a new key, set by the last.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_key_loaded <= 1'b0;
        end else if (w_key_accept) begin
            if (w_key_last) begin
                r_key_loaded <= 1'b1;
            end else if (w_key_first) begin
                r_key_loaded <= 1'b0;
            end
        end
    end

    assign key_loaded     = r_key_loaded;
    assign core_key       = w_key_reg;
    assign core_plaintext = w_blk_reg;
    assign out_data       = w_out_reg[BLOCK_BITS-1 -: LOADER_BYTE_W];

`ifdef PRESENT_BLOCK_CNT_EN
    logic [15:0] r_blk_count;

    // Count blocks whose last ciphertext byte has been accepted; wraps freely.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_blk_count <= 16'd0;
        end else if (w_out_accept && w_out_last) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`else
    assign blk_count = 16'd0;
`endif

endmodule
